// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one load/store outstanding, a fixed number of
// wait states, then a held response carrying load data or a misaligned/out-of-range flag.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [31:0]   mem [DEPTH];
    logic          acc_err;
    logic [AW-1:0] widx;
    logic          mem_we;

    // Full 30-bit word index is range-checked so high address bits never alias.
    assign acc_err = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
    assign widx    = addr_q[AW+1:2];

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // WAIT always lasts WAIT_CYCLES+1 cycles, so the response
                // lands WAIT_CYCLES+1 edges after acceptance, including WAIT_CYCLES=0.
                if (cnt_q == 4'd0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = acc_err;
                    resp_rdata_d = (!acc_err && !write_q) ? mem[widx] : 32'd0;
                    mem_we       = write_q && !acc_err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Array contents survive reset; a store commits only on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (mem_we) mem[widx] <= wdata_q;
    end

endmodule
